// File: rtl/brushless_pkg.sv
// Shared types and constants for the brushless commutation stage:
// phase select codes, hall state encodings, duty constants and the commutation table.
package brushless_pkg;

  typedef enum logic [1:0] {
    SEL_COAST = 2'b00,
    SEL_REV   = 2'b01,
    SEL_FWD   = 2'b10,
    SEL_BRAKE = 2'b11
  } sel_e;

  typedef struct packed {
    sel_e grn;
    sel_e ylw;
    sel_e blu;
  } phase_sel_t;

  // Hall states are {Grn,Ylw,Blu}; the six valid ones are listed in rotation order.
  localparam logic [2:0] HALL_S0   = 3'b101;
  localparam logic [2:0] HALL_S1   = 3'b100;
  localparam logic [2:0] HALL_S2   = 3'b110;
  localparam logic [2:0] HALL_S3   = 3'b010;
  localparam logic [2:0] HALL_S4   = 3'b011;
  localparam logic [2:0] HALL_S5   = 3'b001;
  localparam logic [2:0] HALL_BAD0 = 3'b000;
  localparam logic [2:0] HALL_BAD7 = 3'b111;

  localparam logic [10:0] DUTY_BASE  = 11'h400;
  localparam logic [10:0] DUTY_BRAKE = 11'h600;

  localparam phase_sel_t SEL_ALL_COAST = '{grn: SEL_COAST, ylw: SEL_COAST, blu: SEL_COAST};
  localparam phase_sel_t SEL_ALL_BRAKE = '{grn: SEL_BRAKE, ylw: SEL_BRAKE, blu: SEL_BRAKE};

  function automatic logic hall_valid(input logic [2:0] s);
    return (s != HALL_BAD0) && (s != HALL_BAD7);
  endfunction

  function automatic phase_sel_t commutate(input logic [2:0] s);
    phase_sel_t p;
    p = SEL_ALL_COAST;
    case (s)
      HALL_S0: p = '{grn: SEL_FWD,   ylw: SEL_REV,   blu: SEL_COAST};
      HALL_S1: p = '{grn: SEL_FWD,   ylw: SEL_COAST, blu: SEL_REV};
      HALL_S2: p = '{grn: SEL_COAST, ylw: SEL_FWD,   blu: SEL_REV};
      HALL_S3: p = '{grn: SEL_REV,   ylw: SEL_FWD,   blu: SEL_COAST};
      HALL_S4: p = '{grn: SEL_REV,   ylw: SEL_COAST, blu: SEL_FWD};
      HALL_S5: p = '{grn: SEL_COAST, ylw: SEL_REV,   blu: SEL_FWD};
      default: p = SEL_ALL_COAST;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/brushless_hall_sync.sv
// Two-flop synchronizers for the three halls and brake_n, plus the rotation_state
// register that only loads on PWM_synch.
module hall_sync
  import brushless_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hall_grn,
  input  logic       hall_ylw,
  input  logic       hall_blu,
  input  logic       brake_n,
  input  logic       pwm_synch,
  output logic [2:0] sync_state,
  output logic       brake_n_sync,
  output logic [2:0] rotation_state
);

  // Bit 3 is brake_n; it resets high so a reset never looks like a brake request.
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [2:0] state_q, state_d;

  always_comb begin
    sync1_d = {brake_n, hall_grn, hall_ylw, hall_blu};
    sync2_d = sync1_q;
    state_d = state_q;
    if (pwm_synch) state_d = sync2_q[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b1000;
      sync2_q <= 4'b1000;
      state_q <= HALL_BAD0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
    end
  end

  // sync_state is the sample about to be taken; rotation_state is the one held from the last PWM_synch.
  assign sync_state     = sync2_q[2:0];
  assign brake_n_sync   = sync2_q[3];
  assign rotation_state = state_q;

endmodule

// File: rtl/brushless_ctrl.sv
// Commutation and duty stage: samples halls at PWM period boundaries, selects phase drive,
// scales drv_mag to duty and handles coast/stall/invalid-hall. Optional brake via BRUSHLESS_BRAKE_EN.
module brushless_ctrl
  import brushless_pkg::*;
#(
  parameter int STALL_PERIODS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic [11:0] drv_mag,
  input  logic        PWM_synch,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic [10:0] duty,
  output logic        hall_err,
  output logic        hall_edge,
  output logic        stalled
);

  localparam int CW = $clog2(STALL_PERIODS + 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_PERIODS);

  logic [2:0] sync_state;
  logic [2:0] rotation_state;
  logic       brake_n_sync;
  logic       braking;

  hall_sync u_hall_sync (
    .clk            (clk),
    .rst            (rst),
    .hall_grn       (hallGrn),
    .hall_ylw       (hallYlw),
    .hall_blu       (hallBlu),
    .brake_n        (brake_n),
    .pwm_synch      (PWM_synch),
    .sync_state     (sync_state),
    .brake_n_sync   (brake_n_sync),
    .rotation_state (rotation_state)
  );

`ifdef BRUSHLESS_BRAKE_EN
  assign braking = !brake_n_sync;
`else
  logic unused_brake;
  assign unused_brake = brake_n_sync;
  assign braking      = 1'b0;
`endif

  phase_sel_t    sel_q, sel_d;
  logic [10:0]   duty_q, duty_d;
  logic          hall_err_q, hall_err_d;
  logic          hall_edge_q, hall_edge_d;
  logic          stalled_q, stalled_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          changed;
  logic          driving;

  assign changed = (sync_state != rotation_state);
  assign driving = (drv_mag != 12'd0);

  always_comb begin
    sel_d       = sel_q;
    duty_d      = duty_q;
    hall_err_d  = hall_err_q;
    hall_edge_d = 1'b0;
    stalled_d   = stalled_q;
    cnt_d       = cnt_q;
    if (PWM_synch) begin
      if (!braking) begin
        if (changed || !driving)   cnt_d = '0;
        else if (cnt_q != STALL_MAX) cnt_d = cnt_q + 1'b1;
      end
      // A hall change resets the count but only a zero drive releases the lockout.
      if (!driving)                stalled_d = 1'b0;
      else if (cnt_d == STALL_MAX) stalled_d = 1'b1;

      hall_edge_d = changed && hall_valid(sync_state) && hall_valid(rotation_state);

      sel_d      = SEL_ALL_COAST;
      duty_d     = 11'd0;
      hall_err_d = 1'b0;
      if (braking) begin
        sel_d  = SEL_ALL_BRAKE;
        duty_d = DUTY_BRAKE;
      end else if (stalled_d) begin
        sel_d = SEL_ALL_COAST;
      end else if (!hall_valid(sync_state)) begin
        hall_err_d = 1'b1;
      end else if (driving) begin
        sel_d  = commutate(sync_state);
        duty_d = DUTY_BASE + {1'b0, drv_mag[11:2]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= SEL_ALL_COAST;
      duty_q      <= 11'd0;
      hall_err_q  <= 1'b0;
      hall_edge_q <= 1'b0;
      stalled_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sel_q       <= sel_d;
      duty_q      <= duty_d;
      hall_err_q  <= hall_err_d;
      hall_edge_q <= hall_edge_d;
      stalled_q   <= stalled_d;
      cnt_q       <= cnt_d;
    end
  end

  assign selGrn    = sel_q.grn;
  assign selYlw    = sel_q.ylw;
  assign selBlu    = sel_q.blu;
  assign duty      = duty_q;
  assign hall_err  = hall_err_q;
  assign hall_edge = hall_edge_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_brushless_ctrl.sv
// Directed bench for brushless_ctrl with STALL_PERIODS=4; brake expectations follow BRUSHLESS_BRAKE_EN.
module tb_brushless_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        PWM_synch;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        hall_err, hall_edge, stalled;

  int vectors = 0;
  int miscompares = 0;

  brushless_ctrl #(.STALL_PERIODS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hallGrn   (hallGrn),
    .hallYlw   (hallYlw),
    .hallBlu   (hallBlu),
    .brake_n   (brake_n),
    .drv_mag   (drv_mag),
    .PWM_synch (PWM_synch),
    .selGrn    (selGrn),
    .selYlw    (selYlw),
    .selBlu    (selBlu),
    .duty      (duty),
    .hall_err  (hall_err),
    .hall_edge (hall_edge),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_halls(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
    tick(); tick(); tick();
  endtask

  task automatic pulse();
    PWM_synch = 1'b1;
    tick();
    PWM_synch = 1'b0;
  endtask

  task automatic pulse2();
    PWM_synch = 1'b1;
    tick(); tick();
    PWM_synch = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] g, input logic [1:0] y,
                           input logic [1:0] b, input logic [10:0] d, input logic err,
                           input logic edg, input logic stl);
    chk({tag, ".sel"}, {10'd0, selGrn, selYlw, selBlu}, {10'd0, g, y, b});
    chk({tag, ".duty"}, {5'd0, duty}, {5'd0, d});
    chk({tag, ".hall_err"}, {15'd0, hall_err}, {15'd0, err});
    chk({tag, ".hall_edge"}, {15'd0, hall_edge}, {15'd0, edg});
    chk({tag, ".stalled"}, {15'd0, stalled}, {15'd0, stl});
  endtask

  initial begin
    rst = 1'b1; brake_n = 1'b1; drv_mag = 12'd0; PWM_synch = 1'b0;
    {hallGrn, hallYlw, hallBlu} = 3'b000;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check_out("reset", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);

    // No PWM_synch yet: outputs stay at reset values.
    drv_mag = 12'h800;
    set_halls(3'b101);
    check_out("hold_before_synch", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("first_101", 2'b10, 2'b01, 2'b00, 11'h600, 1'b0, 1'b0, 1'b0);

    // Mid-period hall change is not visible until the next synch.
    set_halls(3'b100);
    check_out("mid_period_hold", 2'b10, 2'b01, 2'b00, 11'h600, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("edge_100", 2'b10, 2'b00, 2'b01, 11'h600, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("edge_drop", 2'b10, 2'b00, 2'b01, 11'h600, 1'b0, 1'b0, 1'b0);

    // Invalid hall and recovery without an edge.
    set_halls(3'b111);
    pulse();
    check_out("invalid_111", 2'b00, 2'b00, 2'b00, 11'h000, 1'b1, 1'b0, 1'b0);
    set_halls(3'b110);
    pulse();
    check_out("recover_110", 2'b00, 2'b10, 2'b01, 11'h600, 1'b0, 1'b0, 1'b0);

    // Glitch between synchs is invisible.
    set_halls(3'b010);
    set_halls(3'b110);
    pulse();
    check_out("glitch_hidden", 2'b00, 2'b10, 2'b01, 11'h600, 1'b0, 1'b0, 1'b0);

    // Stall: fixed halls 011, drv_mag 0x100 -> duty 0x440.
    drv_mag = 12'h100;
    set_halls(3'b011);
    pulse();
    check_out("stall_start", 2'b01, 2'b00, 2'b10, 11'h440, 1'b0, 1'b1, 1'b0);
    pulse2();
    check_out("back_to_back", 2'b01, 2'b00, 2'b10, 11'h440, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    pulse();
    check_out("stall_cnt3", 2'b01, 2'b00, 2'b10, 11'h440, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("stalled", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b1);

    // A hall change alone keeps the lockout.
    set_halls(3'b001);
    pulse();
    check_out("stall_hall_change", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b1, 1'b1);

    // Brake request while stalled.
    brake_n = 1'b0;
    tick(); tick(); tick();
    pulse();
`ifdef BRUSHLESS_BRAKE_EN
    check_out("brake_stalled", 2'b11, 2'b11, 2'b11, 11'h600, 1'b0, 1'b0, 1'b1);
`else
    check_out("brake_ignored", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b1);
`endif
    brake_n = 1'b1;
    tick(); tick(); tick();

    // Zero drive releases the stall.
    drv_mag = 12'h000;
    pulse();
    check_out("stall_release", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
    drv_mag = 12'h100;
    pulse();
    check_out("drive_001", 2'b00, 2'b01, 2'b10, 11'h440, 1'b0, 1'b0, 1'b0);

    // Hall change at the 3rd period restarts the count.
    pulse();
    pulse();
    set_halls(3'b101);
    pulse();
    check_out("count_reset_edge", 2'b10, 2'b01, 2'b00, 11'h440, 1'b0, 1'b1, 1'b0);
    pulse(); pulse(); pulse();
    check_out("count_reset_cnt3", 2'b10, 2'b01, 2'b00, 11'h440, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("count_reset_stall", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b1);

    // Max duty, then reset mid-operation.
    drv_mag = 12'h000;
    pulse();
    drv_mag = 12'hFFF;
    pulse();
    check_out("duty_max", 2'b10, 2'b01, 2'b00, 11'h7FF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_out("mid_reset", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_out("post_reset_hold", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("post_reset_first", 2'b10, 2'b01, 2'b00, 11'h7FF, 1'b0, 1'b0, 1'b0);
    pulse(); pulse(); pulse();
    check_out("post_reset_cnt3", 2'b10, 2'b01, 2'b00, 11'h7FF, 1'b0, 1'b0, 1'b0);
    pulse();
    check_out("post_reset_stall", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
